mux_scan_serializer: RTL
========================

Name: mux_scan_serializer

Overview:
- Upstream control stage for the team's 4:1 multiplexer (ports I[3:0], S[1:0], Y).
- Accepts a parallel word over a valid/ready handshake and holds it on the mux data inputs.
- Steps the mux select through every channel and registers each returned mux output bit onto a serial valid/ready stream with a last-bit marker.
- The mux itself stays external; this block drives mux_i and mux_s and reads mux_y.

Parameters:
- NUM_CH, 4: channel count. Equals mux data width and serial word length. Must be a power of two ≥2.
- SEL_W, 2: select width, equal to log2(NUM_CH).
- MSB_FIRST, 0: 0 gives select order 0→NUM_CH-1. 1 gives select order NUM_CH-1→0.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- in_data  in  NUM_CH  parallel word to serialize
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a word
- mux_i  out  NUM_CH  held word, wired to mux I
- mux_s  out  SEL_W  current select, wired to mux S
- mux_y  in  1  mux output Y (combinational from mux_i/mux_s)
- ser_bit  out  1  serial data bit
- ser_idx  out  SEL_W  channel index ser_bit came from
- ser_last  out  1  ser_bit is the final bit of the word
- ser_valid  out  1  ser_bit/ser_idx/ser_last valid
- ser_ready  in  1  downstream accepts serial bit
- busy  out  1  state is SCAN

Behaviour:
- Reset, asynchronous on rst high:
  - state=IDLE
  - mux_i=0, mux_s=0
  - ser_bit=0, ser_idx=0, ser_last=0, ser_valid=0
  - busy=0, in_ready=0 while rst is high
  - Any word in progress is discarded and no partial output survives.
- States: IDLE and SCAN. in_ready = (state==IDLE) && !rst. busy = (state==SCAN).
- IDLE:
  - On in_valid && in_ready at an edge: mux_i<=in_data. mux_s<=0 (MSB_FIRST=0) or NUM_CH-1 (MSB_FIRST=1). Go to SCAN.
  - in_data is ignored when no handshake occurs.
- SCAN:
  - Define slot_free = !ser_valid || ser_ready.
  - On each edge with slot_free: ser_bit<=mux_y, ser_idx<=mux_s, ser_valid<=1, ser_last<=(mux_s is the final index).
  - If that index is not final, mux_s steps by ±1. If it is final, return to IDLE with mux_s unchanged.
  - Without slot_free: hold everything. mux_s does not advance (backpressure stall).
- Output register outside SCAN: if ser_valid && ser_ready and no new sample is loaded, ser_valid<=0. ser_bit, ser_idx and ser_last hold their last values.
- Stability: mux_i is stable from capture until the next accepted word. The final bit may still be pending in the output register while IDLE accepts the next word. This is legal because the output register is independent of mux_i.
- Latency, no backpressure:
  - Handshake at edge 0.
  - First ser_valid after edge 1 (sample of select 0 taken at edge 1).
  - Bit k is presented after edge 1+k.
  - Return to IDLE at edge NUM_CH.
  - Next handshake no earlier than edge NUM_CH+1.
  - Peak throughput is NUM_CH bits per NUM_CH+1 cycles.
- Simultaneous events: a stalled ser_valid with ser_ready arriving on the same edge as a new sample counts as accept-and-reload. ser_valid stays 1 and the new bit is presented.
- Select arithmetic is unsigned SEL_W bits. Because the state changes at the final index, the select never wraps.
- Mid-word reset: an assertion in any cycle immediately forces the reset values. After release, the first new handshake restarts at the first index.

Test Plan:
- Basic: reset, release, send in_data=4'b1010 with ser_ready=1 → ser_bit sequence 0,1,0,1. ser_idx 0,1,2,3. ser_last high only on idx 3. mux_s 0,1,2,3. in_ready low for 4 cycles.
- MSB_FIRST=1, in_data=4'b1010 → ser_bit 1,0,1,0. ser_idx 3,2,1,0. ser_last on idx 0.
- Backpressure: in_data=4'b0110, ser_ready low for 3 cycles after first valid → ser_bit 0 and idx 0 held stable. mux_s stays 1. Release yields 0,1,1,0 with no loss or duplication.
- Back-to-back words: 4'b1010 then 4'b0101 with in_valid held high → second handshake occurs in the cycle after the last sample of the first word. Serial stream is 0,1,0,1,1,0,1,0 with ser_last on bits 4 and 8.
- Reset mid-word: assert rst after the second bit of 4'b1111 → all outputs 0 immediately. After release, in_data=4'b0001 yields 1,0,0,0.
- Idle ignore: in_valid low with in_data toggling → mux_i, ser_valid and busy unchanged at 0.

Source files
------------

// File: rtl/mux_scan_serializer.sv
// Captures a parallel word and drives it onto an external NUM_CH:1 mux. It then walks the
// mux select across every channel and emits each returned bit on a serial valid/ready stream.
module mux_scan_serializer #(
    parameter int NUM_CH    = 4,
    parameter int SEL_W     = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [NUM_CH-1:0] mux_i,
    output logic [SEL_W-1:0]  mux_s,
    input  logic              mux_y,
    output logic              ser_bit,
    output logic [SEL_W-1:0]  ser_idx,
    output logic              ser_last,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              busy
);

    localparam logic [SEL_W-1:0] FIRST_IDX = MSB_FIRST ? SEL_W'(NUM_CH - 1) : '0;
    localparam logic [SEL_W-1:0] LAST_IDX  = MSB_FIRST ? '0 : SEL_W'(NUM_CH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [NUM_CH-1:0]   r_mux_i;
    logic [NUM_CH-1:0]   w_mux_i_next;
    logic [SEL_W-1:0]    r_mux_s;
    logic [SEL_W-1:0]    w_mux_s_next;
    logic                r_ser_bit;
    logic                w_ser_bit_next;
    logic [SEL_W-1:0]    r_ser_idx;
    logic [SEL_W-1:0]    w_ser_idx_next;
    logic                r_ser_last;
    logic                w_ser_last_next;
    logic                r_ser_valid;
    logic                w_ser_valid_next;

    logic                w_in_ready;
    logic                w_slot_free;
    logic                w_final;
    logic [SEL_W-1:0]    w_step;

    assign w_in_ready  = (r_state == ST_IDLE) && !rst;
    assign w_slot_free = !r_ser_valid || ser_ready;
    assign w_final     = (r_mux_s == LAST_IDX);
    // The select never wraps: the scan leaves SCAN on the final index instead of stepping.
    assign w_step      = MSB_FIRST ? (r_mux_s - 1'b1) : (r_mux_s + 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_mux_i     <= '0;
            r_mux_s     <= '0;
            r_ser_bit   <= 1'b0;
            r_ser_idx   <= '0;
            r_ser_last  <= 1'b0;
            r_ser_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_mux_i     <= w_mux_i_next;
            r_mux_s     <= w_mux_s_next;
            r_ser_bit   <= w_ser_bit_next;
            r_ser_idx   <= w_ser_idx_next;
            r_ser_last  <= w_ser_last_next;
            r_ser_valid <= w_ser_valid_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_mux_i_next     = r_mux_i;
        w_mux_s_next     = r_mux_s;
        w_ser_bit_next   = r_ser_bit;
        w_ser_idx_next   = r_ser_idx;
        w_ser_last_next  = r_ser_last;
        w_ser_valid_next = r_ser_valid;

        // Drain the output register. A reload below overrides this, which makes it accept-and-reload.
        if (r_ser_valid && ser_ready) begin
            w_ser_valid_next = 1'b0;
        end

        unique case (r_state)
            ST_IDLE: begin
                if (in_valid && w_in_ready) begin
                    w_mux_i_next = in_data;
                    w_mux_s_next = FIRST_IDX;
                    w_state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_slot_free) begin
                    w_ser_bit_next   = mux_y;
                    w_ser_idx_next   = r_mux_s;
                    w_ser_last_next  = w_final;
                    w_ser_valid_next = 1'b1;
                    if (w_final) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_mux_s_next = w_step;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = w_in_ready;
    assign busy      = (r_state == ST_SCAN);
    assign mux_i     = r_mux_i;
    assign mux_s     = r_mux_s;
    assign ser_bit   = r_ser_bit;
    assign ser_idx   = r_ser_idx;
    assign ser_last  = r_ser_last;
    assign ser_valid = r_ser_valid;

endmodule
